// File: rtl/rom_addr_gen_pkg.sv
// Shared types and helpers for the VGA image-ROM address generator.
package rom_addr_pkg;

    // Generator state: idle until the first frame boundary, then running.
    typedef enum logic {
        FRAME_WAIT = 1'b0,
        ACTIVE     = 1'b1
    } state_e;

    localparam int MAX_SCALE_LOG2 = 3;

    // Per-frame configuration, latched at each frame boundary.
    typedef struct packed {
        logic [9:0] x_origin;
        logic [9:0] y_origin;
        logic [1:0] scale_log2;
        logic       tile_mode;
    } addr_cfg_t;

    // Last sub-pixel index for a replication factor of 2**s.
    function automatic logic [2:0] sub_max_f(input logic [1:0] s);
        return 3'((4'd1 << s) - 4'd1);
    endfunction

endpackage

// File: rtl/rom_addr_gen_if.sv
// Timing-counter / config inputs and ROM address outputs of the generator.
interface rom_addr_gen_if #(
    parameter int ADDR_W = 16
) ();
    logic [9:0]        H_Count_Value;
    logic [9:0]        V_Count_Value;
    logic              enable_horizontal;
    logic              enable_vertical;
    logic [9:0]        x_origin;
    logic [9:0]        y_origin;
    logic [1:0]        scale_log2;
    logic              tile_mode;
    logic [ADDR_W-1:0] image_addr;
    logic              addr_valid;
    logic              data_valid;
    logic              frame_start;

    // Side that owns the counters and config registers.
    modport master (
        output H_Count_Value, V_Count_Value, enable_horizontal, enable_vertical,
        output x_origin, y_origin, scale_log2, tile_mode,
        input  image_addr, addr_valid, data_valid, frame_start
    );

    // The address generator itself.
    modport slave (
        input  H_Count_Value, V_Count_Value, enable_horizontal, enable_vertical,
        input  x_origin, y_origin, scale_log2, tile_mode,
        output image_addr, addr_valid, data_valid, frame_start
    );
endinterface

// File: rtl/rom_addr_gen_valid_delay.sv
// Delays a valid strobe by LAT cycles to line it up with ROM read data.
module valid_delay #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vld_in,
    output logic vld_out
);

    generate
        if (LAT == 0) begin : g_pass
            assign vld_out = vld_in;
        end else begin : g_pipe
            logic [LAT-1:0] vld_pipe_d, vld_pipe_q;
            logic [LAT:0]   vld_cat;

            // Shift the new strobe in at bit 0; the oldest falls off the top.
            always_comb begin
                vld_cat    = {vld_pipe_q, vld_in};
                vld_pipe_d = vld_cat[LAT-1:0];
            end

            // Pipeline register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) vld_pipe_q <= '0;
                else        vld_pipe_q <= vld_pipe_d;
            end

            assign vld_out = vld_pipe_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/rom_addr_gen.sv
// VGA image-ROM address generator: origin offset, 2**s pixel replication,
// optional tiling; row/column tracked incrementally so no multiplier is needed.
module rom_addr_gen
    import rom_addr_pkg::*;
#(
    parameter int IMG_W    = 200,
    parameter int IMG_H    = 200,
    parameter int ADDR_W   = 16,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ROM_LAT  = 1
) (
    input logic          clk_25M,
    input logic          rst_n,
    rom_addr_gen_if.slave bus
);

    localparam int COL_W = $clog2(IMG_W + 1);
    localparam int ROW_W = $clog2(IMG_H + 1);

    generate
        if (IMG_W * IMG_H > 2 ** ADDR_W) begin : g_bad_addr_w
            $error("rom_addr_gen: IMG_W*IMG_H does not fit in ADDR_W bits");
        end
        if (ROM_LAT < 0 || ROM_LAT > 4) begin : g_bad_lat
            $error("rom_addr_gen: ROM_LAT must be 0..4");
        end
        if (V_ACTIVE > 1024 || H_ACTIVE > 1024) begin : g_bad_active
            $error("rom_addr_gen: active area exceeds 10-bit counters");
        end
    endgenerate

    state_e            state_d, state_q;
    addr_cfg_t         cfg_d, cfg_q, cur_cfg;
    logic [ADDR_W-1:0] row_base_d, row_base_q, cur_row_base;
    logic [ROW_W-1:0]  row_d, row_q, cur_row;
    logic [COL_W-1:0]  col_d, col_q, cur_col;
    logic [2:0]        vsub_d, vsub_q, cur_vsub;
    logic [2:0]        hsub_d, hsub_q, cur_hsub;
    logic [ADDR_W-1:0] image_addr_d, image_addr_q;
    logic              addr_valid_d, addr_valid_q;
    logic              frame_start_d, frame_start_q;

    logic              visible, boundary, eol, active;
    logic [2:0]        sub_max;
    logic [12:0]       h13, v13, x_lo, x_hi, y_lo, y_hi;
    logic              in_h, in_v, pix_in;

    // Frame and line events decoded from the raw counters.
    always_comb begin
        visible  = bus.enable_horizontal & bus.enable_vertical;
        boundary = visible && bus.H_Count_Value == 10'd0 && bus.V_Count_Value == 10'd0;
        eol      = visible && bus.H_Count_Value == 10'(H_ACTIVE - 1);
    end

    // At a boundary the pixel being presented already uses the new config and
    // a cleared row/column state, so (0,0) of every frame is addressed right.
    always_comb begin
        cur_cfg      = cfg_q;
        cur_row_base = row_base_q;
        cur_row      = row_q;
        cur_col      = col_q;
        cur_vsub     = vsub_q;
        cur_hsub     = hsub_q;
        if (boundary) begin
            cur_cfg.x_origin   = bus.x_origin;
            cur_cfg.y_origin   = bus.y_origin;
            cur_cfg.scale_log2 = bus.scale_log2;
            cur_cfg.tile_mode  = bus.tile_mode;
            cur_row_base       = '0;
            cur_row            = '0;
            cur_col            = '0;
            cur_vsub           = '0;
            cur_hsub           = '0;
        end
    end

    // Window test in 13 bits so windows running off-screen just clip.
    always_comb begin
        active  = (state_q == ACTIVE) || boundary;
        sub_max = sub_max_f(cur_cfg.scale_log2);
        h13     = 13'(bus.H_Count_Value);
        v13     = 13'(bus.V_Count_Value);
        x_lo    = 13'(cur_cfg.x_origin);
        y_lo    = 13'(cur_cfg.y_origin);
        x_hi    = x_lo + (13'(IMG_W) << cur_cfg.scale_log2);
        y_hi    = y_lo + (13'(IMG_H) << cur_cfg.scale_log2);
        // Row/col bounds also keep the address inside the image.
        in_h    = cur_cfg.tile_mode ||
                  (h13 >= x_lo && h13 < x_hi && cur_col < COL_W'(IMG_W));
        in_v    = cur_cfg.tile_mode ||
                  (v13 >= y_lo && v13 < y_hi && cur_row < ROW_W'(IMG_H));
        pix_in  = visible && active && in_h && in_v;
    end

    // Next-state: config shadow, FSM, row/column trackers and outputs.
    always_comb begin
        state_d       = state_q;
        cfg_d         = cur_cfg;
        row_base_d    = cur_row_base;
        row_d         = cur_row;
        col_d         = cur_col;
        vsub_d        = cur_vsub;
        hsub_d        = cur_hsub;
        image_addr_d  = '0;
        addr_valid_d  = 1'b0;
        frame_start_d = boundary;

        if (boundary) state_d = ACTIVE;

        // Advance one source column every 2**s in-window pixels.
        if (pix_in) begin
            if (cur_hsub == sub_max) begin
                hsub_d = '0;
                if (cur_cfg.tile_mode && cur_col == COL_W'(IMG_W - 1)) col_d = '0;
                else                                                   col_d = cur_col + COL_W'(1);
            end else begin
                hsub_d = cur_hsub + 3'd1;
            end
            image_addr_d = cur_row_base + ADDR_W'(cur_col);
            addr_valid_d = 1'b1;
        end

        // End of line: restart columns, advance a source row every 2**s lines.
        if (active && eol) begin
            col_d  = '0;
            hsub_d = '0;
            if (in_v) begin
                if (cur_vsub == sub_max) begin
                    vsub_d = '0;
                    if (cur_cfg.tile_mode && cur_row == ROW_W'(IMG_H - 1)) begin
                        row_d      = '0;
                        row_base_d = '0;
                    end else begin
                        row_d      = cur_row + ROW_W'(1);
                        row_base_d = cur_row_base + ADDR_W'(IMG_W);
                    end
                end else begin
                    vsub_d = cur_vsub + 3'd1;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk_25M or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FRAME_WAIT;
            cfg_q         <= '0;
            row_base_q    <= '0;
            row_q         <= '0;
            col_q         <= '0;
            vsub_q        <= '0;
            hsub_q        <= '0;
            image_addr_q  <= '0;
            addr_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cfg_q         <= cfg_d;
            row_base_q    <= row_base_d;
            row_q         <= row_d;
            col_q         <= col_d;
            vsub_q        <= vsub_d;
            hsub_q        <= hsub_d;
            image_addr_q  <= image_addr_d;
            addr_valid_q  <= addr_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    valid_delay #(.LAT(ROM_LAT)) u_valid_delay (
        .clk     (clk_25M),
        .rst_n   (rst_n),
        .vld_in  (addr_valid_q),
        .vld_out (bus.data_valid)
    );

    assign bus.image_addr  = image_addr_q;
    assign bus.addr_valid  = addr_valid_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_rom_addr_gen.sv
// Directed bench for rom_addr_gen (200x200 image, 640x480 screen, ROM_LAT=2).
// Counters are driven sparsely: only the pixels that matter plus each line end.
module tb_rom_addr_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    rom_addr_gen_if #(.ADDR_W(16)) bus ();

    rom_addr_gen #(
        .IMG_W(200), .IMG_H(200), .ADDR_W(16),
        .H_ACTIVE(640), .V_ACTIVE(480), .ROM_LAT(2)
    ) dut (
        .clk_25M (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one visible pixel; returns #1 after the edge that registers it.
    task automatic px(input int h, input int v);
        @(negedge clk);
        bus.H_Count_Value     = 10'(h);
        bus.V_Count_Value     = 10'(v);
        bus.enable_horizontal = 1'b1;
        bus.enable_vertical   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic eol_lines(input int a, input int b);
        for (int v = a; v <= b; v++) px(639, v);
    endtask

    task automatic set_cfg(input int x, input int y, input int s, input int t);
        bus.x_origin   = 10'(x);
        bus.y_origin   = 10'(y);
        bus.scale_log2 = 2'(s);
        bus.tile_mode  = 1'(t);
    endtask

    task automatic chk_px(input string tag, input int addr, input int vld);
        chk({tag, ".addr"},  32'(bus.image_addr), 32'(addr));
        chk({tag, ".valid"}, 32'(bus.addr_valid), 32'(vld));
    endtask

    initial begin
        bus.H_Count_Value     = '0;
        bus.V_Count_Value     = '0;
        bus.enable_horizontal = 1'b0;
        bus.enable_vertical   = 1'b0;
        set_cfg(0, 0, 0, 0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.addr",  32'(bus.image_addr), 0);
        chk("rst.valid", 32'(bus.addr_valid), 0);
        chk("rst.dv",    32'(bus.data_valid), 0);
        chk("rst.fs",    32'(bus.frame_start), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // No output before the first boundary
        px(5, 3);
        chk_px("wait", 0, 0);

        // Default config
        px(0, 0);
        chk_px("A.h0", 0, 1);
        chk("A.fs0", 32'(bus.frame_start), 1);
        chk("A.dv0", 32'(bus.data_valid), 0);
        for (int h = 1; h <= 200; h++) begin
            px(h, 0);
            chk_px("A.line0", (h < 200) ? h : 0, (h < 200) ? 1 : 0);
            chk("A.dv", 32'(bus.data_valid), (h >= 2) ? 1 : 0);
            if (h == 1) chk("A.fs1", 32'(bus.frame_start), 0);
        end
        px(201, 0);
        chk("A.dv_tail", 32'(bus.data_valid), 1);
        px(202, 0);
        chk("A.dv_off", 32'(bus.data_valid), 0);
        px(639, 0);
        px(0, 1);
        chk_px("A.v1", 200, 1);
        px(639, 1);
        eol_lines(2, 198);
        for (int h = 0; h <= 199; h++) px(h, 199);
        chk_px("A.last", 39999, 1);
        px(200, 199);
        chk_px("A.last_r", 0, 0);
        px(639, 199);
        px(0, 200);
        chk_px("A.v200", 0, 0);
        px(639, 200);
        eol_lines(201, 479);

        // scale_log2 = 1
        set_cfg(0, 0, 1, 0);
        px(0, 0);
        chk_px("B.h0", 0, 1);
        chk("B.fs", 32'(bus.frame_start), 1);
        for (int h = 1; h <= 400; h++) begin
            px(h, 0);
            chk_px("B.line0", (h < 400) ? (h >> 1) : 0, (h < 400) ? 1 : 0);
        end
        px(639, 0);
        for (int h = 0; h <= 3; h++) begin
            px(h, 1);
            chk_px("B.v1", h >> 1, 1);
        end
        px(639, 1);
        px(0, 2);
        chk_px("B.v2", 200, 1);
        px(639, 2);
        eol_lines(3, 398);
        px(0, 399);
        chk_px("B.v399", 39800, 1);
        px(639, 399);
        px(0, 400);
        chk_px("B.v400", 0, 0);
        px(639, 400);
        eol_lines(401, 479);

        // Origin (100,50)
        set_cfg(100, 50, 0, 0);
        px(0, 0);
        chk_px("C.h0", 0, 0);
        chk("C.fs", 32'(bus.frame_start), 1);
        px(639, 0);
        eol_lines(1, 49);
        for (int h = 0; h <= 100; h++) begin
            px(h, 50);
            if (h == 99)  chk_px("C.h99", 0, 0);
            if (h == 100) chk_px("C.h100", 0, 1);
        end
        px(639, 50);
        eol_lines(51, 248);
        for (int h = 0; h <= 300; h++) begin
            px(h, 249);
            if (h == 299) chk_px("C.last", 39999, 1);
            if (h == 300) chk_px("C.past", 0, 0);
        end
        px(639, 249);
        eol_lines(250, 479);

        // Tile mode, origin must be ignored
        set_cfg(100, 50, 0, 1);
        px(0, 0);
        chk_px("D.h0", 0, 1);
        for (int h = 1; h <= 639; h++) begin
            px(h, 0);
            if (h == 199) chk_px("D.h199", 199, 1);
            if (h == 200) chk_px("D.h200", 0, 1);
            if (h == 439) chk_px("D.h439", 39, 1);
        end
        eol_lines(1, 199);
        px(0, 200);
        chk_px("D.v200", 0, 1);
        px(639, 200);
        eol_lines(201, 478);
        for (int h = 0; h <= 639; h++) px(h, 479);
        chk_px("D.corner", 15839, 1);

        // Mid-frame config change applies only at the next boundary
        set_cfg(0, 0, 0, 0);
        px(0, 0);
        chk_px("E.h0", 0, 1);
        chk("E.fs", 32'(bus.frame_start), 1);
        px(639, 0);
        eol_lines(1, 9);
        bus.x_origin = 10'd100;
        px(0, 10);
        chk_px("E.v10", 2000, 1);
        px(639, 10);
        eol_lines(11, 479);
        px(0, 0);
        chk_px("E.new_h0", 0, 0);
        chk("E.fs_new", 32'(bus.frame_start), 1);
        px(1, 0);
        chk("E.fs_once", 32'(bus.frame_start), 0);
        for (int h = 2; h <= 100; h++) begin
            px(h, 0);
            if (h == 99)  chk_px("E.h99", 0, 0);
            if (h == 100) chk_px("E.h100", 0, 1);
        end
        px(639, 0);

        // Asynchronous reset mid-frame
        eol_lines(1, 4);
        px(100, 5);
        chk_px("F.v5", 1000, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_px("F.rst", 0, 0);
        chk("F.rst_dv", 32'(bus.data_valid), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        px(100, 6);
        chk_px("F.v6", 0, 0);
        chk("F.v6_dv", 32'(bus.data_valid), 0);
        px(639, 6);
        px(100, 7);
        chk_px("F.v7", 0, 0);
        set_cfg(0, 0, 0, 0);
        px(0, 0);
        chk_px("F.h0", 0, 1);
        chk("F.dv0", 32'(bus.data_valid), 0);
        px(1, 0);
        chk_px("F.h1", 1, 1);
        chk("F.dv1", 32'(bus.data_valid), 0);
        px(2, 0);
        chk("F.dv2", 32'(bus.data_valid), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
